// File: rtl/sysarr3x3_host_ctrl.sv
// sysarr3x3_host_ctrl
//   Host-side controller for the 3x3 systolic array. It gathers 18 operand
//   bytes (A row-major, then B row-major) from a byte-serial ready/valid
//   stream, runs the start/valid handshake with the array, latches C and
//   streams the 9 result bytes back out on a byte-serial ready/valid port.
//
// Ports
//   clk, rst            system clock; asynchronous active-high reset
//   s_data/s_valid/s_ready   inbound operand byte stream
//   m_data/m_valid/m_ready   outbound result byte stream
//   arr_A, arr_B        operands to the array, element k=3i+j at [8k+7:8k]
//   arr_start           start request to the array
//   arr_valid, arr_C    result-valid and result from the array
//   busy                high in every state except LOAD
//   timeout_err         sticky, set when the array does not answer in time
//
// state   | meaning
// LOAD    | accept operand bytes 0..17 from the host
// START   | wait for a stale arr_valid to clear, then raise arr_start
// WAIT    | hold arr_start, wait for arr_valid or timeout
// RELEASE | arr_start low, wait for the array to drop arr_valid
// DRAIN   | stream result bytes 0..8 to the host
module sysarr3x3_host_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [71:0] arr_A,
  output logic [71:0] arr_B,
  output logic        arr_start,
  input  logic        arr_valid,
  input  logic [71:0] arr_C,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {LOAD, START, WAIT, RELEASE, DRAIN} state_t;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

  state_t        state, state_n;
  logic [143:0]  opnd, opnd_n;      // {B, A}
  logic [71:0]   result, result_n;
  logic [4:0]    idx, idx_n;        // load byte index, reused as drain index
  logic [15:0]   tcnt, tcnt_n;
  logic [16:0]   tcnt_inc;
  logic [4:0]    idx_inc;
  logic          s_ready_n, m_valid_n, arr_start_n, busy_n, timeout_err_n;
  logic [7:0]    m_data_n;

  assign arr_A    = opnd[71:0];
  assign arr_B    = opnd[143:72];
  assign tcnt_inc = {1'b0, tcnt} + 17'd1;
  assign idx_inc  = idx + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      opnd        <= '0;
      result      <= '0;
      idx         <= '0;
      tcnt        <= '0;
      s_ready     <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      arr_start   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      opnd        <= opnd_n;
      result      <= result_n;
      idx         <= idx_n;
      tcnt        <= tcnt_n;
      s_ready     <= s_ready_n;
      m_valid     <= m_valid_n;
      m_data      <= m_data_n;
      arr_start   <= arr_start_n;
      busy        <= busy_n;
      timeout_err <= timeout_err_n;
    end
  end

  always_comb begin
    state_n       = state;
    opnd_n        = opnd;
    result_n      = result;
    idx_n         = idx;
    tcnt_n        = tcnt;
    s_ready_n     = s_ready;
    m_valid_n     = m_valid;
    m_data_n      = m_data;
    arr_start_n   = arr_start;
    timeout_err_n = timeout_err;

    case (state)
      LOAD: begin
        // s_ready comes up on the first edge out of reset.
        s_ready_n = 1'b1;
        if (s_valid && s_ready) begin
          opnd_n[{idx, 3'b000} +: 8] = s_data;
          if (idx == 5'd17) begin
            idx_n     = '0;
            s_ready_n = 1'b0;
            state_n   = START;
          end else begin
            idx_n = idx_inc;
          end
        end
      end
      START: begin
        // A valid still high here belongs to an earlier, abandoned run.
        if (!arr_valid) begin
          arr_start_n = 1'b1;
          tcnt_n      = '0;
          state_n     = WAIT;
        end
      end
      WAIT: begin
        tcnt_n = (tcnt_inc >= TO_LIM) ? TO_LIM[15:0] : tcnt_inc[15:0];
        if (arr_valid) begin
          result_n    = arr_C;
          arr_start_n = 1'b0;
          state_n     = RELEASE;
        end else if (tcnt_inc >= TO_LIM) begin
          result_n      = '0;
          timeout_err_n = 1'b1;
          arr_start_n   = 1'b0;
          state_n       = RELEASE;
        end
      end
      RELEASE: begin
        if (!arr_valid) begin
          m_valid_n = 1'b1;
          m_data_n  = result[7:0];
          idx_n     = '0;
          state_n   = DRAIN;
        end
      end
      DRAIN: begin
        if (m_valid && m_ready) begin
          if (idx == 5'd8) begin
            m_valid_n = 1'b0;
            s_ready_n = 1'b1;
            idx_n     = '0;
            state_n   = LOAD;
          end else begin
            idx_n    = idx_inc;
            m_data_n = result[{idx_inc, 3'b000} +: 8];
          end
        end
      end
      default: state_n = LOAD;
    endcase

    busy_n = (state_n != LOAD);
  end

endmodule
